// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: state encoding, byte width and sizing helper shared by the UART transmit arbiter
package uart_tx_arbiter_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [4:0] {
        IDLE       = 5'b00001,
        ISSUE      = 5'b00010,
        WAIT_START = 5'b00100,
        WAIT_DONE  = 5'b01000,
        RELEASE    = 5'b10000
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: round-robin priority encoder, first asserted request at or above rr with wrap-around
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int s;
        logic [W-1:0] j;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(rr) + k;
            s = (s >= N) ? s - N : s;
            j = W'(s);
            idx = req[j] ? j : idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one UART_Tx among NUM_REQ byte requesters
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int IW             = clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           uart_data_en,
    output logic [UART_BYTE_W-1:0]         uart_data,
    input  logic                           uart_tx_en,
    input  logic                           uart_tx_done,
    output logic [IW-1:0]                  grant_id,
    output logic                           busy,
    output logic                           err_timeout
);

    localparam int CW = clog2(TIMEOUT_CYCLES + 1);

    arb_state_e             state, state_n;
    logic [IW-1:0]          rr, rr_n, grant_n, pick_idx, sel, grant_inc;
    logic                   pick_any, go, lock, lock_n, err_n, data_en_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [NUM_REQ-1:0]     ready_n;
    logic [UART_BYTE_W-1:0] data_n;

    rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
        .req(req_valid),
        .rr (rr),
        .idx(pick_idx),
        .any(pick_any)
    );

    // A locked packet ignores every requester except the current owner
    assign sel       = lock ? grant_id : pick_idx;
    assign go        = lock ? req_valid[grant_id] : pick_any;
    assign grant_inc = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    always_comb begin
        state_n   = state;
        rr_n      = rr;
        lock_n    = lock;
        cnt_n     = cnt;
        grant_n   = grant_id;
        err_n     = err_timeout;
        data_en_n = 1'b0;
        ready_n   = '0;
        data_n    = uart_data;
        case (state)
            IDLE: if (go) begin
                state_n   = ISSUE;
                grant_n   = sel;
                data_en_n = 1'b1;
                ready_n   = NUM_REQ'(1) << sel;
                data_n    = req_data[sel*UART_BYTE_W +: UART_BYTE_W];
            end
            ISSUE: begin
                lock_n  = ~req_last[grant_id];
                cnt_n   = '0;
                state_n = WAIT_START;
            end
            WAIT_START: if (uart_tx_en) begin
                state_n = WAIT_DONE;
            end else begin
                cnt_n = cnt + CW'(1);
                if (cnt_n == CW'(TIMEOUT_CYCLES)) begin
                    err_n   = 1'b1;
                    lock_n  = 1'b0;
                    rr_n    = grant_inc;
                    state_n = IDLE;
                end
            end
            WAIT_DONE: state_n = uart_tx_done ? RELEASE : WAIT_DONE;
            RELEASE: if (!uart_tx_done) begin
                state_n = IDLE;
                rr_n    = lock ? rr : grant_inc;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr           <= '0;
            lock         <= 1'b0;
            cnt          <= '0;
            grant_id     <= '0;
            err_timeout  <= 1'b0;
            uart_data_en <= 1'b0;
            req_ready    <= '0;
            uart_data    <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            rr           <= rr_n;
            lock         <= lock_n;
            cnt          <= cnt_n;
            grant_id     <= grant_n;
            err_timeout  <= err_n;
            uart_data_en <= data_en_n;
            req_ready    <= ready_n;
            uart_data    <= data_n;
            busy         <= state_n != IDLE;
        end
    end

endmodule
